// File: rtl/tmds_encoder_multi.sv
// Multi-lane TMDS / TERC4 / guard-band encoder, two-stage pipeline.
// Each lane keeps its own running disparity, mirrored on disp for debug.
module tmds_encoder_multi #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode,
  input  logic [8*NUM_CH-1:0]     vd,
  input  logic [2*NUM_CH-1:0]     cd,
  input  logic [4*NUM_CH-1:0]     ad,
  output logic [10*NUM_CH-1:0]    tmds,
  output logic [CNT_W*NUM_CH-1:0] disp
);

  typedef enum logic [1:0] {
    M_CTL   = 2'd0,
    M_VID   = 2'd1,
    M_TERC  = 2'd2,
    M_GUARD = 2'd3
  } mode_e;

  typedef logic signed [CNT_W-1:0] cnt_t;

  localparam cnt_t EIGHT = cnt_t'(8);
  localparam cnt_t TWO   = cnt_t'(2);
  localparam cnt_t ZERO  = cnt_t'(0);

  function automatic logic [9:0] ctl_sym(input logic [1:0] c);
    logic [9:0] s;
    unique case (c)
      2'b00: s = 10'b1101010100;
      2'b01: s = 10'b0010101011;
      2'b10: s = 10'b0101010100;
      2'b11: s = 10'b1010101011;
    endcase
    return s;
  endfunction

  function automatic logic [9:0] terc_sym(input logic [3:0] a);
    logic [9:0] s;
    unique case (a)
      4'd0:  s = 10'b1010011100;
      4'd1:  s = 10'b1001100011;
      4'd2:  s = 10'b1011100100;
      4'd3:  s = 10'b1011100010;
      4'd4:  s = 10'b0101110001;
      4'd5:  s = 10'b0100011110;
      4'd6:  s = 10'b0110001110;
      4'd7:  s = 10'b0100111100;
      4'd8:  s = 10'b1011001100;
      4'd9:  s = 10'b0100111001;
      4'd10: s = 10'b0110011100;
      4'd11: s = 10'b1011000110;
      4'd12: s = 10'b1010001110;
      4'd13: s = 10'b1001110001;
      4'd14: s = 10'b0101100011;
      4'd15: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  mode_e mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= M_CTL;
    end else begin
      mode_q <= mode_e'(mode);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam logic [9:0] GB =
      (k % 2 == 0) ? 10'b1011001100 : 10'b0100110011;

    logic [7:0] d;
    logic [3:0] n1;
    logic [3:0] n1q;
    logic       xnr;
    logic [8:0] qm_d;
    cnt_t       n1s;
    cnt_t       diff_d;

    logic [1:0] cd_q;
    logic [3:0] ad_q;
    logic [8:0] qm_q;
    cnt_t       diff_q;

    logic [9:0] tmds_d, tmds_q;
    cnt_t       cnt_d, cnt_q;

    logic cnt_z, diff_z, same;

    assign d = vd[8*k +: 8];

    always_comb begin
      n1 = '0;
      for (int i = 0; i < 8; i++) begin
        n1 = n1 + {3'b000, d[i]};
      end
      xnr = (n1 > 4'd4) | ((n1 == 4'd4) & ~d[0]);
      qm_d = '0;
      qm_d[0] = d[0];
      for (int i = 1; i < 8; i++) begin
        qm_d[i] = qm_d[i-1] ^ d[i] ^ xnr;
      end
      qm_d[8] = ~xnr;
      n1q = '0;
      for (int i = 0; i < 8; i++) begin
        n1q = n1q + {3'b000, qm_d[i]};
      end
      // diff = n1 - n0 = 2*n1 - 8 over the eight data bits
      n1s    = cnt_t'(n1q);
      diff_d = n1s + n1s - EIGHT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cd_q   <= '0;
        ad_q   <= '0;
        qm_q   <= '0;
        diff_q <= '0;
      end else begin
        cd_q   <= cd[2*k +: 2];
        ad_q   <= ad[4*k +: 4];
        qm_q   <= qm_d;
        diff_q <= diff_d;
      end
    end

    assign cnt_z  = (cnt_q == ZERO);
    assign diff_z = (diff_q == ZERO);
    assign same   =
      (~cnt_q[CNT_W-1] & ~diff_q[CNT_W-1]) |
      ( cnt_q[CNT_W-1] &  diff_q[CNT_W-1]);

    always_comb begin
      tmds_d = '0;
      cnt_d  = ZERO;
      unique case (mode_q)
        M_CTL:   tmds_d = ctl_sym(cd_q);
        M_TERC:  tmds_d = terc_sym(ad_q);
        M_GUARD: tmds_d = GB;
        M_VID: begin
          if (cnt_z | diff_z) begin
            tmds_d = {~qm_q[8], qm_q[8],
                      qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_d  = qm_q[8] ? cnt_q + diff_q
                             : cnt_q - diff_q;
          end else if (same) begin
            tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_d  = cnt_q + (qm_q[8] ? TWO : ZERO) - diff_q;
          end else begin
            tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_d  = cnt_q + diff_q - (qm_q[8] ? ZERO : TWO);
          end
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tmds_q <= '0;
        cnt_q  <= ZERO;
      end else begin
        tmds_q <= tmds_d;
        cnt_q  <= cnt_d;
      end
    end

    assign tmds[10*k +: 10]      = tmds_q;
    assign disp[CNT_W*k +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Scoreboard bench for tmds_encoder_multi: random video/control traffic
// against a symbol-level model that tracks disparity of emitted symbols.
module tb_tmds_encoder_multi;
  localparam int NCH = 3;
  localparam int CW  = 5;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b1;
  logic [1:0]         mode  = '0;
  logic [8*NCH-1:0]   vd    = '0;
  logic [2*NCH-1:0]   cd    = '0;
  logic [4*NCH-1:0]   ad    = '0;
  logic [10*NCH-1:0]  tmds;
  logic [CW*NCH-1:0]  disp;

  tmds_encoder_multi #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mode (mode),
    .vd   (vd),
    .cd   (cd),
    .ad   (ad),
    .tmds (tmds),
    .disp (disp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [9:0] CTL [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };
  localparam logic [9:0] TERC [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  typedef struct {
    int                 due;
    logic [10*NCH-1:0]  t;
    logic [CW*NCH-1:0]  d;
  } exp_t;

  typedef struct {
    int         due;
    int         ch;
    logic [9:0] t;
    int         d;
  } lit_t;

  exp_t sb[$];
  lit_t lq[$];
  int   mcnt[NCH];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Video symbol choice from the DC-balance rules; the caller updates
  // the running count from the ones-count of the chosen symbol.
  function automatic logic [9:0] vid_sym(input logic [7:0] d,
                                         input int cnt);
    int n1, bal;
    logic xnr;
    logic [8:0] qm;
    n1  = $countones(d);
    xnr = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i] ^ xnr;
    qm[8] = !xnr;
    bal = 2 * $countones(qm[7:0]) - 8;
    if (cnt == 0 || bal == 0)
      return qm[8] ? {2'b01, qm[7:0]} : {2'b10, ~qm[7:0]};
    if ((cnt > 0) == (bal > 0))
      return {1'b1, qm[8], ~qm[7:0]};
    return {1'b0, qm[8], qm[7:0]};
  endfunction

  task automatic drive(input logic [1:0] m, input logic [8*NCH-1:0] v,
                       input logic [2*NCH-1:0] c,
                       input logic [4*NCH-1:0] a, output int due);
    exp_t e;
    logic [9:0] s;
    @(negedge clk);
    mode = m; vd = v; cd = c; ad = a;
    due = cyc + 2;
    e.due = due;
    for (int k = 0; k < NCH; k++) begin
      case (m)
        2'd0:    s = CTL[c[2*k +: 2]];
        2'd1:    s = vid_sym(v[8*k +: 8], mcnt[k]);
        2'd2:    s = TERC[a[4*k +: 4]];
        default: s = (k % 2 == 0) ? 10'b1011001100 : 10'b0100110011;
      endcase
      if (m == 2'd1) mcnt[k] = mcnt[k] + 2 * $countones(s) - 10;
      else           mcnt[k] = 0;
      e.t[10*k +: 10] = s;
      e.d[CW*k +: CW] = CW'(mcnt[k]);
    end
    sb.push_back(e);
  endtask

  task automatic release_rst();
    exp_t e;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NCH; k++) mcnt[k] = 0;
    // cleared stage 1 emits ctl 00, then the held ctl 00 inputs follow
    for (int j = 1; j <= 2; j++) begin
      e.due = cyc + j;
      e.t   = {NCH{10'b1101010100}};
      e.d   = '0;
      sb.push_back(e);
    end
  endtask

  task automatic monitor();
    exp_t e;
    lit_t l;
    logic signed [CW-1:0] dv;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("tmds", 32'(tmds), 32'(e.t));
        chk("disp", 32'(disp), 32'(e.d));
        for (int k = 0; k < NCH; k++) begin
          dv = disp[CW*k +: CW];
          chk("disp_bound", 32'(dv > 5'sd10 || dv < -5'sd10), 32'd0);
        end
      end
      if (lq.size() > 0 && lq[0].due == cyc) begin
        l  = lq.pop_front();
        dv = disp[CW*l.ch +: CW];
        chk("lit_tmds", 32'(tmds[10*l.ch +: 10]), 32'(l.t));
        chk("lit_disp", 32'(int'(dv)), 32'(l.d));
      end
    end
  endtask

  initial begin
    int due;
    logic [1:0] m;
    logic [8*NCH-1:0] rv;
    logic [2*NCH-1:0] rc;
    logic [4*NCH-1:0] ra;
    for (int k = 0; k < NCH; k++) mcnt[k] = 0;
    fork
      monitor();
    join_none

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tmds", 32'(tmds), 32'd0);
    chk("rst_disp", 32'(disp), 32'd0);
    release_rst();

    for (int c = 0; c < 4; c++)
      drive(2'd0, '0, {NCH{2'(c)}}, '0, due);

    drive(2'd1, '0, '0, '0, due);
    lq.push_back('{due, 0, 10'b0100000000, -8});
    drive(2'd1, '0, '0, '0, due);
    lq.push_back('{due, 0, 10'b1111111111, 2});
    drive(2'd1, '0, '0, '0, due);
    lq.push_back('{due, 0, 10'b0100000000, -6});

    for (int a = 0; a < 16; a++) begin
      drive(2'd2, '0, '0, {NCH{4'(a)}}, due);
      if (a == 0)  lq.push_back('{due, 0, 10'b1010011100, 0});
      if (a == 15) lq.push_back('{due, 2, 10'b1011000011, 0});
    end

    drive(2'd3, '0, '0, '0, due);
    lq.push_back('{due, 1, 10'b0100110011, 0});
    drive(2'd1, '0, '0, '0, due);
    lq.push_back('{due, 0, 10'b0100000000, -8});

    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        mode = 2'd0;
        cd   = '0;
        #1;
        chk("arst_tmds", 32'(tmds), 32'd0);
        chk("arst_disp", 32'(disp), 32'd0);
        sb.delete();
        lq.delete();
        @(negedge clk);
        release_rst();
      end
      if ($urandom_range(0, 15) == 0) begin
        int len;
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) begin
          m  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3))
                                           : 2'd0;
          rv = (8*NCH)'($urandom);
          rc = (2*NCH)'($urandom);
          ra = (4*NCH)'($urandom);
          drive(m, rv, rc, ra, due);
        end
      end else begin
        rv = (8*NCH)'($urandom);
        drive(2'd1, rv, '0, '0, due);
      end
    end

    repeat (4) @(negedge clk);
    chk("drain_sb", 32'(sb.size()), 32'd0);
    chk("drain_lit", 32'(lq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
